// File: rtl/issue_window_pkg.sv
// Shared pipeline types for the issue stage: decoded instruction record,
// register index width, and the pairwise same-cycle conflict check.
package issue_window_pkg;

    localparam int REG_N_DEF = 32;
    localparam int REG_W     = $clog2(REG_N_DEF);

    typedef struct packed {
        logic [REG_W-1:0] w_reg;
        logic [REG_W-1:0] r_reg0;
        logic [REG_W-1:0] r_reg1;
        logic             need_csr;
        logic             invalid_inst;
        logic             need_mul;
        logic             need_div;
        logic             need_lsu;
        logic             need_bpu;
    } inst_t;

    // True when 'late' may not issue in the same cycle as the older 'early'.
    function automatic logic pair_conflict(input inst_t early, input inst_t late);
        logic data_c;
        logic struct_c;
        data_c = (early.w_reg != '0) &&
                 ((early.w_reg == late.r_reg0) ||
                  (early.w_reg == late.r_reg1) ||
                  (early.w_reg == late.w_reg));
        struct_c = early.need_csr | early.invalid_inst |
                   late.need_csr  | late.invalid_inst  |
                   (early.need_mul & late.need_mul) |
                   (early.need_div & late.need_div) |
                   (early.need_lsu & late.need_lsu) |
                   (early.need_bpu & late.need_bpu);
        return data_c | struct_c;
    endfunction

endpackage

// File: rtl/issue_window_scoreboard.sv
// Busy bit per architectural register for pending long-latency writes.
// Clears apply before sets so a same-cycle set on the same register wins.
module issue_scoreboard
    import issue_window_pkg::*;
#(
    parameter int REG_N   = REG_N_DEF,
    parameter int ISSUE_W = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [ISSUE_W-1:0]              set_valid_i,
    input  logic [ISSUE_W-1:0][REG_W-1:0]   set_reg_i,
    input  logic [ISSUE_W-1:0]              clr_valid_i,
    input  logic [ISSUE_W-1:0][REG_W-1:0]   clr_reg_i,
    output logic [REG_N-1:0]                busy_o
);

    logic [REG_N-1:0] busy_q;
    logic [REG_N-1:0] busy_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (clr_valid_i[k]) busy_d[clr_reg_i[k]] = 1'b0;
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            if (set_valid_i[k]) busy_d[set_reg_i[k]] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush_i) busy_d = '0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/issue_window.sv
// In-order issue window: DEPTH-entry circular queue issuing up to ISSUE_W
// instructions per cycle. Define ISSUE_SCOREBOARD_EN to add the busy-register scoreboard.
module issue_window
    import issue_window_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 4,
    parameter int REG_N   = REG_N_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  inst_t [ISSUE_W-1:0]             inst_i,
    input  logic [ISSUE_W-1:0]              valid_i,
    output logic                            ready_o,
    output inst_t [ISSUE_W-1:0]             inst_o,
    output logic                            ex_valid_o,
    input  logic                            ex_ready_i,
    output logic [ISSUE_W-1:0]              is_o,
    input  logic [ISSUE_W-1:0]              wb_valid_i,
    input  logic [ISSUE_W-1:0][REG_W-1:0]   wb_reg_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int n);
        return PTR_W'((int'(p) + n) % DEPTH);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [ISSUE_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < ISSUE_W; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    inst_t [DEPTH-1:0]       mem_q, mem_d;
    logic [REG_N-1:0]        busy;
    logic [ISSUE_W-1:0]      blocked, ok;
    logic                    push;
    logic [CNT_W-1:0]        push_n, pop_n;

    assign ready_o = (DEPTH - int'(count_q)) >= ISSUE_W;
    assign push    = valid_i[0] && ready_o && !flush_i;
    assign push_n  = push ? popcount(valid_i) : '0;
    assign pop_n   = popcount(is_o);

    always_comb begin
        inst_o = '0;
        for (int k = 0; k < ISSUE_W; k++) inst_o[k] = mem_q[wrap_add(head_q, k)];
    end

    // Each slot needs every older slot to issue and to be free of pairwise conflicts.
    always_comb begin
        logic [ISSUE_W-1:0] ok_v;
        ok_v    = '0;
        blocked = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            blocked[k] = busy[inst_o[k].r_reg0] | busy[inst_o[k].r_reg1] | busy[inst_o[k].w_reg];
            ok_v[k]    = (k < int'(count_q)) && !blocked[k];
            if (k > 0) begin
                ok_v[k] = ok_v[k] && ok_v[k-1];
                for (int j = 0; j < k; j++) begin
                    if (pair_conflict(inst_o[j], inst_o[k])) ok_v[k] = 1'b0;
                end
            end
        end
        ok = ok_v;
    end

    assign ex_valid_o = ok[0];
    assign is_o       = ok & {ISSUE_W{ex_ready_i & ~flush_i}};

    always_comb begin
        mem_d   = mem_q;
        head_d  = wrap_add(head_q, int'(pop_n));
        tail_d  = tail_q;
        count_d = count_q + push_n - pop_n;
        if (push) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (valid_i[k]) mem_d[wrap_add(tail_q, k)] = inst_i[k];
            end
            tail_d = wrap_add(tail_q, int'(push_n));
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: queue storage is not reset; entries are only consumed below count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ISSUE_SCOREBOARD_EN
    logic [ISSUE_W-1:0]            sb_set;
    logic [ISSUE_W-1:0][REG_W-1:0] sb_set_reg;

    always_comb begin
        sb_set     = '0;
        sb_set_reg = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            sb_set[k]     = is_o[k] && (inst_o[k].w_reg != '0) &&
                            (inst_o[k].need_mul | inst_o[k].need_div | inst_o[k].need_lsu);
            sb_set_reg[k] = inst_o[k].w_reg;
        end
    end

    issue_scoreboard #(
        .REG_N   (REG_N),
        .ISSUE_W (ISSUE_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .set_valid_i (sb_set),
        .set_reg_i   (sb_set_reg),
        .clr_valid_i (wb_valid_i),
        .clr_reg_i   (wb_reg_i),
        .busy_o      (busy)
    );
`else
    logic unused_wb;
    assign busy      = '0;
    assign unused_wb = ^{wb_valid_i, wb_reg_i};
`endif

endmodule
